// File: rtl/exmem_pipe.sv
// exmem_pipe: dual-lane EX->MEM pipeline register with multiply-wait control.
//
// Captures each lane's result, store data, destination register and control bits
// from the execute stage. While a multi-cycle multiply in either lane is still
// pending, the front end is stalled and bubbles are fed into MEM. Both lanes
// always advance together. A watchdog forces release after TIMEOUT cycles.
//
// Ports:
//   clk_i, resetn_i         clock, synchronous active-low reset
//   flushm_i                load bubbles into both lanes, abort any multiply wait
//   *e_i / *e2_i            lane1 / lane2 execute-stage inputs
//   multsele*_i             execute op in that lane is a multiply
//   multready*_i            multiplier result valid this cycle in that lane
//   *m_o / *m2_o            registered lane1 / lane2 MEM-stage copies
//   stallmult_o             combinational freeze of PC/IF/ID/ID-EX this cycle
//   multtimeout_o           sticky watchdog flag, cleared only by reset
module exmem_pipe #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk_i,
    input  logic             resetn_i,
    input  logic             flushm_i,
    input  logic             regwritee_i,
    input  logic             memtorege_i,
    input  logic             memwritee_i,
    input  logic [WIDTH-1:0] solutione_i,
    input  logic [WIDTH-1:0] writedatae_i,
    input  logic [4:0]       writerege_i,
    input  logic             multsele_i,
    input  logic             multready_i,
    input  logic             regwritee2_i,
    input  logic             memtorege2_i,
    input  logic             memwritee2_i,
    input  logic [WIDTH-1:0] solutione2_i,
    input  logic [WIDTH-1:0] writedatae2_i,
    input  logic [4:0]       writerege2_i,
    input  logic             multsele2_i,
    input  logic             multready2_i,
    output logic             regwritem_o,
    output logic             memtoregm_o,
    output logic             memwritem_o,
    output logic [WIDTH-1:0] aluoutm_o,
    output logic [WIDTH-1:0] writedatam_o,
    output logic [4:0]       writeregm_o,
    output logic             regwritem2_o,
    output logic             memtoregm2_o,
    output logic             memwritem2_o,
    output logic [WIDTH-1:0] aluoutm2_o,
    output logic [WIDTH-1:0] writedatam2_o,
    output logic [4:0]       writeregm2_o,
    output logic             stallmult_o,
    output logic             multtimeout_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);

    typedef enum logic [0:0] {StIdle, StMwait} state_e;

    typedef struct packed {
        logic             regwrite;
        logic             memtoreg;
        logic             memwrite;
        logic [WIDTH-1:0] alu;
        logic [WIDTH-1:0] wdata;
        logic [4:0]       wreg;
    } lane_t;

    state_e          state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    logic            rdy1_q, rdy1_d;
    logic            rdy2_q, rdy2_d;
    logic            timeout_q, timeout_d;
    lane_t           lane1_q, lane1_d;
    lane_t           lane2_q, lane2_d;
    logic            need1, need2;
    logic            load_ex;

    // A lane still needs to wait only if its product has never been seen valid.
    assign need1 = multsele_i & ~(rdy1_q | multready_i);
    assign need2 = multsele2_i & ~(rdy2_q | multready2_i);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        rdy1_d      = rdy1_q;
        rdy2_d      = rdy2_q;
        timeout_d   = timeout_q;
        stallmult_o = 1'b0;
        load_ex     = 1'b0;

        if (flushm_i) begin
            state_d = StIdle;
            count_d = '0;
            rdy1_d  = 1'b0;
            rdy2_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (need1 | need2) begin
                        stallmult_o = 1'b1;
                        state_d     = StMwait;
                        count_d     = CntW'(1);
                        rdy1_d      = multready_i;
                        rdy2_d      = multready2_i;
                    end else begin
                        load_ex = 1'b1;
                    end
                end
                StMwait: begin
                    rdy1_d  = rdy1_q | multready_i;
                    rdy2_d  = rdy2_q | multready2_i;
                    count_d = count_q + CntW'(1);
                    if (!(need1 | need2) || count_q >= CntW'(TIMEOUT)) begin
                        // Timeout releases whatever is on the EX bus, possibly stale.
                        load_ex = 1'b1;
                        state_d = StIdle;
                        count_d = '0;
                        rdy1_d  = 1'b0;
                        rdy2_d  = 1'b0;
                        if (need1 | need2) begin
                            timeout_d = 1'b1;
                        end
                    end else begin
                        stallmult_o = 1'b1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    // Anything other than a clean load is a bubble: all fields zero.
    always_comb begin
        lane1_d = '0;
        lane2_d = '0;
        if (load_ex) begin
            lane1_d = '{regwrite: regwritee_i, memtoreg: memtorege_i, memwrite: memwritee_i,
                        alu: solutione_i, wdata: writedatae_i, wreg: writerege_i};
            lane2_d = '{regwrite: regwritee2_i, memtoreg: memtorege2_i, memwrite: memwritee2_i,
                        alu: solutione2_i, wdata: writedatae2_i, wreg: writerege2_i};
        end
    end

    always_ff @(posedge clk_i) begin
        if (!resetn_i) begin
            state_q   <= StIdle;
            count_q   <= '0;
            rdy1_q    <= 1'b0;
            rdy2_q    <= 1'b0;
            timeout_q <= 1'b0;
            lane1_q   <= '0;
            lane2_q   <= '0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            rdy1_q    <= rdy1_d;
            rdy2_q    <= rdy2_d;
            timeout_q <= timeout_d;
            lane1_q   <= lane1_d;
            lane2_q   <= lane2_d;
        end
    end

    assign regwritem_o   = lane1_q.regwrite;
    assign memtoregm_o   = lane1_q.memtoreg;
    assign memwritem_o   = lane1_q.memwrite;
    assign aluoutm_o     = lane1_q.alu;
    assign writedatam_o  = lane1_q.wdata;
    assign writeregm_o   = lane1_q.wreg;
    assign regwritem2_o  = lane2_q.regwrite;
    assign memtoregm2_o  = lane2_q.memtoreg;
    assign memwritem2_o  = lane2_q.memwrite;
    assign aluoutm2_o    = lane2_q.alu;
    assign writedatam2_o = lane2_q.wdata;
    assign writeregm2_o  = lane2_q.wreg;
    assign multtimeout_o = timeout_q;

endmodule
